// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, reads the combinational program memory and hands
// instructions to the decoder over valid/ready, with PC-relative branch redirects.
module instruction_fetch #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 16,
  parameter int END_ADDR = 31
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [ADDR_W-1:0]        pm_addr,
  input  logic [DATA_W-1:0]        pm_data,
  output logic [DATA_W-1:0]        instr,
  output logic [ADDR_W-1:0]        instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  input  logic                     br_taken,
  input  logic [ADDR_W-1:0]        br_pc,
  input  logic signed [10:0]       br_offset,
  output logic                     halted
);

  localparam int SUM_W = ((ADDR_W > 11) ? ADDR_W : 11) + 1;

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic                halted_q, halted_d;
  logic [ADDR_W-1:0]   br_target;

  // Target is relative to the instruction after the branch; wraps modulo the PC width.
  function automatic logic [ADDR_W-1:0] branch_target(input logic [ADDR_W-1:0] pc,
                                                      input logic signed [10:0] off);
    logic signed [SUM_W-1:0] base;
    logic signed [SUM_W-1:0] ext;
    logic signed [SUM_W-1:0] sum;
    base = $signed({{(SUM_W-ADDR_W){1'b0}}, pc});
    ext  = $signed({{(SUM_W-11){off[10]}}, off});
    sum  = base + ext + $signed(SUM_W'(1));
    return sum[ADDR_W-1:0];
  endfunction

  assign br_target = branch_target(br_pc, br_offset);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (br_taken) begin
          pc_d          = br_target;
          instr_valid_d = 1'b0;
        end else if (!instr_valid_q || instr_ready) begin
          instr_d       = pm_data;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + ADDR_W'(1);
          if (pc_q == ADDR_W'(END_ADDR)) state_d = HALT;
        end
      end
      HALT: begin
        if (br_taken) begin
          pc_d          = br_target;
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end else if (instr_valid_q && instr_ready) begin
          instr_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign pm_addr     = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;

endmodule
